// File: rtl/unsigned_seq_divider_16by8_pkg.sv
// Shared types and widths for the 16-by-8 restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package unsigned_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int PR_W       = 9;

  // Quotient bits actually computed when the low `trunc` bits are skipped.
  function automatic int iter_count(input int trunc);
    return DIVIDEND_W - trunc;
  endfunction

endpackage

// File: rtl/unsigned_seq_divider_16by8_if.sv
// Operand/result handshake bundle for the sequential divider.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface unsigned_seq_divider_16by8_if;
  import unsigned_div_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] x;
  logic [DIVISOR_W-1:0]  y;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] q;
  logic [DIVISOR_W-1:0]  r;
  logic                  div_zero;

  // Producer/consumer side of the divider.
  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, q, r, div_zero
  );

  // The divider itself.
  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, q, r, div_zero
  );

endinterface

// File: rtl/unsigned_seq_divider_16by8_div_restore_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract y.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports: pr_in/next_bit/y in, pr_out/qbit out.
module div_restore_step
  import unsigned_div_pkg::*;
(
  input  logic [PR_W-1:0]      pr_in,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] y,
  output logic [PR_W-1:0]      pr_out,
  output logic                 qbit
);

  logic [PR_W-1:0] t;
  // The incoming remainder is always < y, so its top bit is never set.
  logic            unused_pr_msb;

  assign unused_pr_msb = pr_in[PR_W-1];

  always_comb begin
    t      = {pr_in[PR_W-2:0], next_bit};
    pr_out = t;
    qbit   = 1'b0;
    if (t >= {1'b0, y}) begin
      pr_out = t - {1'b0, y};
      qbit   = 1'b1;
    end
  end

endmodule

// File: rtl/unsigned_seq_divider_16by8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per cycle, low TRUNC bits skipped.
// Latency: 16-TRUNC+1 cycles accept-to-result (1 cycle for y==0); ports clk, rst_n, bus (slave).
// Backpressure: result held in DONE until out_ready; no new operands accepted until then.
module unsigned_seq_divider_16by8
  import unsigned_div_pkg::*;
#(
  parameter int TRUNC = 0
) (
  input logic                         clk,
  input logic                         rst_n,
  unsigned_seq_divider_16by8_if.slave bus
);

  if (TRUNC < 0 || TRUNC > 15) begin : g_bad_trunc
    $error("unsigned_seq_divider_16by8: TRUNC must be in 0..15");
  end

  localparam int          N    = iter_count(TRUNC);
  localparam logic [3:0]  LAST = 4'(N - 1);

  state_t                state;
  logic [DIVIDEND_W-1:0] xs;
  logic [DIVISOR_W-1:0]  ys;
  logic [PR_W-1:0]       pr;
  logic [DIVIDEND_W-2:0] q_acc;
  logic [3:0]            cnt;

  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  r_q;
  logic                  div_zero_q;

  logic [PR_W-1:0]       pr_next;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] q_next;

  div_restore_step u_step (
    .pr_in    (pr),
    .next_bit (xs[DIVIDEND_W-1]),
    .y        (ys),
    .pr_out   (pr_next),
    .qbit     (qbit)
  );

  assign q_next = {q_acc, qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      xs          <= '0;
      ys          <= '0;
      pr          <= '0;
      q_acc       <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      r_q         <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            xs         <= bus.x;
            ys         <= bus.y;
            pr         <= '0;
            q_acc      <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            if (bus.y == '0) begin
              // Divide-by-zero short-circuits straight to a saturated result.
              state       <= DONE;
              out_valid_q <= 1'b1;
              q_q         <= '1;
              r_q         <= bus.x[DIVISOR_W-1:0];
              div_zero_q  <= 1'b1;
            end else begin
              state      <= BUSY;
              div_zero_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          pr    <= pr_next;
          xs    <= xs << 1;
          q_acc <= q_next[DIVIDEND_W-2:0];
          cnt   <= cnt + 4'd1;
          if (cnt == LAST) begin
            // Only the top N dividend bits were consumed, so the computed
            // quotient is scaled back up to its true bit positions.
            state       <= DONE;
            out_valid_q <= 1'b1;
            q_q         <= q_next << TRUNC;
            r_q         <= pr_next[DIVISOR_W-1:0];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.q         = q_q;
  assign bus.r         = r_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_unsigned_seq_divider_16by8.sv
// Directed bench for the sequential divider: TRUNC=0 and TRUNC=6 instances side by side.
// Latency: checked per vector, counted in clock cycles from the accept edge.
// Backpressure: out_ready held low in one sequence; reset injected mid-divide in another.
module tb_unsigned_seq_divider_16by8;

  logic clk;
  logic rst_n;

  unsigned_seq_divider_16by8_if if0 ();
  unsigned_seq_divider_16by8_if if6 ();

  unsigned_seq_divider_16by8 #(.TRUNC(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  unsigned_seq_divider_16by8 #(.TRUNC(6)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          sel;   // 0: TRUNC=0 instance, 1: TRUNC=6 instance
    logic [15:0] x;
    logic [7:0]  y;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_in(input bit s, input logic v, input logic [15:0] x, input logic [7:0] y);
    if (s) begin
      if6.in_valid = v; if6.x = x; if6.y = y;
    end else begin
      if0.in_valid = v; if0.x = x; if0.y = y;
    end
  endtask

  function automatic logic get_ov(input bit s);
    return s ? if6.out_valid : if0.out_valid;
  endfunction

  function automatic logic get_ir(input bit s);
    return s ? if6.in_ready : if0.in_ready;
  endfunction

  function automatic logic [15:0] get_q(input bit s);
    return s ? if6.q : if0.q;
  endfunction

  function automatic logic [7:0] get_r(input bit s);
    return s ? if6.r : if0.r;
  endfunction

  function automatic logic get_dz(input bit s);
    return s ? if6.div_zero : if0.div_zero;
  endfunction

  // Present operands on a negedge, let the next posedge accept them, then
  // count negedges until out_valid. Operands are scrambled right after accept.
  task automatic start_and_wait(input bit s, input logic [15:0] x, input logic [7:0] y,
                                output int lat);
    drive_in(s, 1'b1, x, y);
    @(posedge clk);
    @(negedge clk);
    drive_in(s, 1'b0, 16'($urandom), 8'($urandom));
    lat = 1;
    while (!get_ov(s) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int lat;
    logic [15:0] hq;
    logic [7:0]  hr;
    logic        hdz;

    vecs.push_back('{0, 16'd59742, 8'd200, 16'd298,   8'd142, 1'b0, 17});
    vecs.push_back('{0, 16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17});
    vecs.push_back('{0, 16'd5,     8'd7,   16'd0,     8'd5,   1'b0, 17});
    vecs.push_back('{0, 16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17});
    vecs.push_back('{0, 16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1, 1});
    vecs.push_back('{0, 16'd255,   8'd16,  16'd15,    8'd15,  1'b0, 17});
    vecs.push_back('{0, 16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 17});
    vecs.push_back('{1, 16'd59742, 8'd200, 16'd256,   8'd133, 1'b0, 11});
    vecs.push_back('{1, 16'd65535, 8'd3,   16'd21824, 8'd0,   1'b0, 11});
    vecs.push_back('{1, 16'd1000,  8'd7,   16'd128,   8'd1,   1'b0, 11});
    vecs.push_back('{1, 16'd100,   8'd0,   16'hFFFF,  8'h64,  1'b1, 1});

    rst_n = 1'b0;
    drive_in(0, 1'b0, '0, '0);
    drive_in(1, 1'b0, '0, '0);
    if0.out_ready = 1'b1;
    if6.out_ready = 1'b1;
    #12;
    chk("reset in_ready",  32'(if0.in_ready),  32'd1);
    chk("reset out_valid", 32'(if0.out_valid), 32'd0);
    chk("reset q",         32'(if0.q),         32'd0);
    chk("reset r",         32'(if0.r),         32'd0);
    chk("reset div_zero",  32'(if0.div_zero),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors; out_ready=1 so each result retires on the next edge.
    foreach (vecs[i]) begin
      start_and_wait(vecs[i].sel, vecs[i].x, vecs[i].y, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d q", i),  32'(get_q(vecs[i].sel)),  32'(vecs[i].q));
      chk($sformatf("vec%0d r", i),  32'(get_r(vecs[i].sel)),  32'(vecs[i].r));
      chk($sformatf("vec%0d dz", i), 32'(get_dz(vecs[i].sel)), 32'(vecs[i].dz));
      @(negedge clk);
      chk($sformatf("vec%0d retire", i), 32'(get_ov(vecs[i].sel)), 32'd0);
    end

    // Backpressure: 1000/7 = 142 r 6, held for 5 cycles.
    if0.out_ready = 1'b0;
    start_and_wait(0, 16'd1000, 8'd7, lat);
    chk("bp latency", 32'(lat), 32'd17);
    hq = 16'd142; hr = 8'd6; hdz = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_in(0, 1'b1, 16'd9, 8'd3);  // must be ignored while DONE
      chk($sformatf("bp%0d out_valid", k), 32'(if0.out_valid), 32'd1);
      chk($sformatf("bp%0d in_ready", k),  32'(if0.in_ready),  32'd0);
      chk($sformatf("bp%0d q", k),         32'(if0.q),         32'(hq));
      chk($sformatf("bp%0d r", k),         32'(if0.r),         32'(hr));
      chk($sformatf("bp%0d dz", k),        32'(if0.div_zero),  32'(hdz));
      @(negedge clk);
    end
    drive_in(0, 1'b0, '0, '0);
    if0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", 32'(if0.out_valid), 32'd0);
    chk("bp release in_ready",  32'(if0.in_ready),  32'd1);
    start_and_wait(0, 16'd300, 8'd3, lat);
    chk("bp next latency", 32'(lat), 32'd17);
    chk("bp next q", 32'(if0.q), 32'd100);
    chk("bp next r", 32'(if0.r), 32'd0);
    @(negedge clk);

    // Reset in the middle of 59742/200, then a clean divide.
    drive_in(0, 1'b1, 16'd59742, 8'd200);
    @(posedge clk);
    @(negedge clk);
    drive_in(0, 1'b0, '0, '0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(if0.out_valid), 32'd0);
    chk("midrst in_ready",  32'(if0.in_ready),  32'd1);
    chk("midrst q",         32'(if0.q),         32'd0);
    chk("midrst r",         32'(if0.r),         32'd0);
    chk("midrst div_zero",  32'(if0.div_zero),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("midrst no stale", 32'(if0.out_valid), 32'd0);
    end
    start_and_wait(0, 16'd1000, 8'd10, lat);
    chk("post-rst latency", 32'(lat), 32'd17);
    chk("post-rst q", 32'(if0.q), 32'd100);
    chk("post-rst r", 32'(if0.r), 32'd0);
    chk("post-rst dz", 32'(if0.div_zero), 32'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
